pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Consumer side of the hazard-detection interface. Takes the ID-stage stall request and the branch-resolution result, then drives the pipeline-register and PC control strobes:
- PC write-enable, IF/ID hold and flush, ID/EX bubble insertion, PC redirect select.
- Tracks stall duration and flags a stall watchdog timeout.

Sits between the hazard detector / branch unit and the IF, IF/ID and ID/EX registers.

Parameters:
FLUSH_DEPTH, 1, number of consecutive cycles ifid_flush_o is held after an accepted taken branch (1..7)
STALL_TIMEOUT, 64, consecutive stall cycles that raise stall_timeout_o (2..255)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
stall_i  in  1  stall request from hazard detector (ID stage)
branch_taken_i  in  1  taken-branch/jump resolved this cycle
pc_we_o  out  1  PC register write enable
pc_sel_o  out  1  1 = PC loads branch target this cycle
ifid_we_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  IF/ID register loads NOP
idex_bubble_o  out  1  ID/EX register loads NOP (control bits zero)
stall_timeout_o  out  1  sticky watchdog flag
state_o  out  2  current FSM state (00 RUN, 01 STALL, 10 FLUSH)
stall_cycles_o  out  CNT_W  total stall cycles (only with PIPE_PERF_CNT_EN)
flush_events_o  out  CNT_W  total accepted taken branches (only with PIPE_PERF_CNT_EN)

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-high; rst_i asserted forces state RUN immediately.
  - While rst_i is high: pc_we_o=0, pc_sel_o=0, ifid_we_o=0, ifid_flush_o=1, idex_bubble_o=1, stall_timeout_o=0, run counter=0, flush counter=0, perf counters=0.
  - Reset mid-stall or mid-flush discards all in-progress state.
  - First cycle after release is RUN with no pending flush.
- Strobes are Mealy outputs of state plus inputs, with zero latency. They act in the same cycle as the request.
- Effective requests:
  - stall_eff = stall_i & (state != FLUSH).
  - br_eff = branch_taken_i & ~stall_i & (state != FLUSH).
  - stall_i has priority over branch_taken_i. A branch is never resolved while its operands are hazarded.
- RUN:
  - Idle outputs: pc_we_o=1, ifid_we_o=1, others 0.
  - stall_eff: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; next state STALL.
  - br_eff: pc_sel_o=1, pc_we_o=1, ifid_flush_o=1, idex_bubble_o=0.
    - FLUSH_DEPTH=1: stay RUN.
    - Otherwise: load flush counter with FLUSH_DEPTH-1; next state FLUSH.
- STALL:
  - Same strobes as a RUN stall while stall_i is high.
  - stall_i low: RUN outputs, br_eff honoured as in RUN; next state RUN, or FLUSH if br_eff and FLUSH_DEPTH>1.
- FLUSH:
  - ifid_flush_o=1, pc_we_o=1, ifid_we_o=1. stall_i and branch_taken_i are ignored (ID holds bubbles).
  - Counter decrements each cycle; state returns to RUN in the cycle after the counter reads 1.
- Watchdog:
  - Run counter, 8 bits, saturating. Increments each cycle stall_eff=1 and clears on any cycle with stall_eff=0.
  - When the counter reaches STALL_TIMEOUT-1 while stalling, stall_timeout_o sets on that clock edge.
  - stall_timeout_o is sticky until reset. It has no effect on strobes.
- state_o reflects the registered state.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cycles_o increments on each stall_eff cycle.
  - flush_events_o increments on each br_eff cycle.
  - Both are CNT_W wide, wrap modulo 2^CNT_W, and reset to 0.
- Undefined: both ports and their registers are absent; all other behaviour is unchanged.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle.
  - Outputs immediately pc_we_o=0, ifid_flush_o=1, idex_bubble_o=1, state_o=00.
  - After release the next cycle shows pc_we_o=1, ifid_we_o=1.
- Load-use: stall_i high 1 cycle.
  - That cycle: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1.
  - Next edge: state_o=01. Following cycle with stall_i=0: state_o returns to 00.
  - stall_cycles_o=1 with macro.
- Taken branch, FLUSH_DEPTH=3: branch_taken_i pulsed 1 cycle.
  - pc_sel_o=1 for exactly 1 cycle; ifid_flush_o=1 for 3 cycles; state_o=10 for 2 cycles.
  - branch_taken_i and stall_i pulsed during FLUSH are ignored; flush_events_o=1.
- Simultaneous stall_i=1 and branch_taken_i=1: stall response only, pc_sel_o=0, ifid_flush_o=0, flush_events_o unchanged.
- Watchdog, STALL_TIMEOUT=4:
  - stall_i held 3 cycles then dropped: stall_timeout_o stays 0.
  - stall_i held 4 cycles: stall_timeout_o=1 after the 4th edge and remains 1 after stall_i drops, until rst_i.
- Reset during FLUSH (FLUSH_DEPTH=5, rst_i at 2nd flush cycle): after release state_o=00 and ifid_flush_o=0 with no residual flush cycles.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard and branch-resolution requests into PC and pipeline-register strobes.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_DEPTH   = 1,
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             stall_timeout_o,
  output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
`endif
);

  localparam int unsigned FC_W  = 3;
  localparam int unsigned RUN_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_e;

  // Elaboration-time parameter range guard
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7 || STALL_TIMEOUT < 2 || STALL_TIMEOUT > 255 || CNT_W < 1)
  begin : g_bad_param
    $error("pipeline_stall_ctrl: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              timeout_q, timeout_d;
  logic              stall_eff_c;
  logic              br_eff_c;

  // A flush window masks both requests: ID only holds bubbles then.
  assign stall_eff_c = stall_i & (state_q != FLUSH);
  assign br_eff_c    = branch_taken_i & ~stall_i & (state_q != FLUSH);

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    run_cnt_d     = '0;
    timeout_d     = timeout_q;
    pc_we_o       = 1'b1;
    pc_sel_o      = 1'b0;
    ifid_we_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;

    case (state_q)
      FLUSH: begin
        ifid_flush_o = 1'b1;
        flush_cnt_d  = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q <= FC_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        if (stall_eff_c) begin
          pc_we_o       = 1'b0;
          ifid_we_o     = 1'b0;
          idex_bubble_o = 1'b1;
          state_d       = STALL;
        end else if (br_eff_c) begin
          pc_sel_o     = 1'b1;
          ifid_flush_o = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FC_W'(FLUSH_DEPTH - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
    endcase

    // Saturating stall-run watchdog; flag is sticky until reset
    if (stall_eff_c) begin
      run_cnt_d = (run_cnt_q == {RUN_W{1'b1}}) ? run_cnt_q : run_cnt_q + RUN_W'(1);
      if (run_cnt_q >= RUN_W'(STALL_TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end
    end

    if (rst_i) begin
      pc_we_o       = 1'b0;
      pc_sel_o      = 1'b0;
      ifid_we_o     = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state_o         = state_q;
  assign stall_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_events_q;

  // Free-running event counters, wrap modulo 2^CNT_W
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_eff_c) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (br_eff_c)    flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;
`endif

endmodule
